// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU: alu_ctl codes, slice op codes and FSM states.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_SUM  = 2'b10;
  localparam logic [1:0] OP_LESS = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Unknown codes collapse to AND so the datapath never sees an odd mix of invert bits.
  function automatic logic [3:0] decode_ctl(input logic [3:0] ctl);
    case (ctl)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: decode_ctl = ctl;
      default:                                            decode_ctl = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: optional input inversion, AND/OR/full-add/less select.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       carry_i,
  input  logic       ainvert_i,
  input  logic       binvert_i,
  input  logic       less_i,
  input  logic [1:0] op_i,
  output logic       result_o,
  output logic       carry_o,
  output logic       sum_o
);

  logic aa, bb;

  always_comb begin
    aa      = a_i ^ ainvert_i;
    bb      = b_i ^ binvert_i;
    sum_o   = aa ^ bb ^ carry_i;
    carry_o = (aa & bb) | (aa & carry_i) | (bb & carry_i);
    case (op_i)
      OP_AND:  result_o = aa & bb;
      OP_OR:   result_o = aa | bb;
      OP_SUM:  result_o = sum_o;
      default: result_o = less_i;
    endcase
  end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU: latches operands, runs one alu_bit_slice LSB first, one bit per clock,
// then presents the result with valid/ready handshakes on both sides.
module serial_alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [3:0]       ctl_q;
  logic [CW-1:0]    cnt_q;
  logic             tail_q, carry_q, msb_sum_q, ovf_raw_q, cout_q, ovf_q;
  logic             s_cin, s_res, s_cout, s_sum;
  logic             accept, is_arith, is_slt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_RUN;
      ST_RUN:  if (tail_q)    state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  always_comb begin
    accept   = in_valid && in_ready;
    is_arith = (ctl_q[1:0] == OP_SUM);
    is_slt   = (ctl_q[1:0] == OP_LESS);
    s_cin    = (cnt_q == '0) ? ctl_q[2] : carry_q;
  end

  alu_bit_slice u_slice (
    .a_i       (a_q[0]),
    .b_i       (b_q[0]),
    .carry_i   (s_cin),
    .ainvert_i (ctl_q[3]),
    .binvert_i (ctl_q[2]),
    .less_i    (1'b0),
    .op_i      (ctl_q[1:0]),
    .result_o  (s_res),
    .carry_o   (s_cout),
    .sum_o     (s_sum)
  );

  // After the last bit, one tail cycle folds the raw MSB carry/sum into the flags
  // (and the SLT set bit) before DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      ctl_q     <= ALU_AND;
      cnt_q     <= '0;
      tail_q    <= 1'b0;
      carry_q   <= 1'b0;
      msb_sum_q <= 1'b0;
      ovf_raw_q <= 1'b0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            a_q     <= a;
            b_q     <= b;
            ctl_q   <= decode_ctl(alu_ctl);
            res_q   <= '0;
            cnt_q   <= '0;
            tail_q  <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!tail_q) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            res_q   <= {s_res, res_q[WIDTH-1:1]};
            carry_q <= s_cout;
            if (cnt_q == LAST_BIT) begin
              tail_q    <= 1'b1;
              msb_sum_q <= s_sum;
              ovf_raw_q <= s_cin ^ s_cout;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end else begin
            cout_q <= (is_arith || is_slt) ? carry_q : 1'b0;
            ovf_q  <= is_arith ? ovf_raw_q : 1'b0;
            if (is_slt) res_q <= {{(WIDTH-1){1'b0}}, msb_sum_q ^ ovf_raw_q};
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    result    = res_q;
    carry_out = cout_q;
    overflow  = ovf_q;
    zero      = (res_q == '0);
  end

endmodule
